temp_buff_feeder: RTL and testbench
===================================

# temp_buff_feeder

Read-side sequencer between the temp-buffer address generator and the systolic array. It enables the address generator, issues one temp-buffer read per generated address, and re-times each returned word into a diagonally skewed row stream, with per-row valids, for the array's west edge. It finishes with a drain phase and a single-cycle `done` pulse to the controller.

## Interface
- `FEATURE_BITS`, default 4: address generator counter width; read address is `2*FEATURE_BITS` bits.
- `DATA_WIDTH`, default 8: bits per array element.
- `ROWS`, default 4: systolic array rows; one temp-buffer word holds `ROWS` elements, row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- `sys_clk`  in  1  clock.
- `reset_n`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  run request from the controller; single-cycle or level.
- `ag_start`  out  1  enable to the address generator.
- `ag_address`  in  2*FEATURE_BITS  current address from the address generator.
- `ag_done`  in  1  address generator finished (sticky until reset).
- `rd_en`  out  1  temp-buffer read enable.
- `rd_addr`  out  2*FEATURE_BITS  temp-buffer read address.
- `rd_data`  in  ROWS*DATA_WIDTH  temp-buffer read data, fixed one-cycle latency.
- `sa_data`  out  ROWS*DATA_WIDTH  skewed row data to the array.
- `sa_valid`  out  ROWS  per-row valid.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM has four states: IDLE, STREAM, DRAIN, DONE.
  - IDLE → STREAM when `start`=1 and `ag_done`=0. A `start` under any other condition is ignored.
  - STREAM → DRAIN on the first cycle in which `ag_done`=1.
  - DRAIN → DONE after exactly ROWS+1 cycles, counted by a drain counter sized to hold ROWS+1.
  - DONE → IDLE unconditionally.
- `ag_start` = (state==STREAM). It is held high for the whole STREAM phase, because the address generator resets its counter if enable drops.
- `rd_en` = (state==STREAM) && !`ag_done`. `rd_addr` = `ag_address` combinationally. The address stream, including its zero-padding skips, is passed through unmodified.
- Read-valid pipe: `rv` <= `rd_en`, so `rv` marks cycles in which `rd_data` is valid.
- Skew: row r of `rd_data` passes through r+1 register stages, tagged with a valid bit. Row r output is therefore registered r+1 cycles after `rd_data`.
- `sa_data` row r is forced to zero whenever `sa_valid[r]`=0. The array never sees stale data.
- `start` while busy has no effect. There is no abort input; reset is the only way to stop a run.
- Reset clears FSM state, drain counter, `rv`, all skew stages and their valids.
- Reset values: `ag_start`=0, `rd_en`=0, `rd_addr` follows `ag_address`, `sa_data`=0, `sa_valid`=0, `busy`=0, `done`=0.

## Timing
- Cycle 0 is the first STREAM cycle, i.e. the cycle after `start` is sampled in IDLE.
- A read issued in cycle t has `rd_data` valid in cycle t+1. `sa_valid[r]` and `sa_data` row r are then valid in cycle t+2+r.
- With the last read in cycle L, `ag_done` rises in cycle L+1, and DRAIN occupies cycles L+1 … L+ROWS+1.
- The last `sa_valid[ROWS-1]` occurs in cycle L+ROWS+1, inside DRAIN.
- `done` is high in cycle L+ROWS+2 only. IDLE is reached in cycle L+ROWS+3.
- Back-to-back reads have no bubbles. Every STREAM cycle with `ag_done`=0 issues exactly one read.
- `ag_done` is sticky, so a second run requires reset. After `done`, `start` is ignored until reset.

## Test plan
1. Reset, then `start` one cycle, with a real address generator (FEATURE_BITS=4, M=9, depth 82) and ROWS=4 → reads are issued in cycles 0..63 with `rd_addr` = 0..7, 9..16, 18..25, …, 63..70; addresses 8, 17, 26, … are never read; `ag_done` rises at cycle 64; `done` pulses in cycle 69; `busy` is low from cycle 70.
2. Buffer word at address a = {4{a[7:0]}} → `sa_valid[0]` first rises in cycle 2 with value 0x00. `sa_data` row 3 first carries 0x00 in cycle 5. Row 0 in cycle 3 = 0x01; row 0 in cycle 10 = 0x09 (skip visible). Invalid rows read 0.
3. Pulse `start` during STREAM and again during DRAIN → no state change; read count stays 64; exactly one `done` pulse.
4. Assert `reset_n`=0 at cycle 30 for 2 cycles → all outputs return to their reset values within the reset cycle; FSM is in IDLE; `start` after release begins a new run at address 0.
5. Hold `ag_done`=1 (stubbed) and pulse `start` → the FSM stays in IDLE; `rd_en`, `ag_start`, `busy` and `done` all stay 0.
6. Stub an address generator that drops `ag_done` high after 1 address, with ROWS=1 → one read at address 0; `sa_valid[0]` in cycle 2; `done` in cycle 3.

Source files
------------

// File: rtl/temp_buff_feeder.sv
// Read-side sequencer: enables the address generator, issues one temp-buffer read per address,
// and re-times each returned word into a diagonally skewed, per-row-valid stream for the array.
module temp_buff_feeder #(
    parameter int FEATURE_BITS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int ROWS         = 4
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         ag_start,
    input  logic [2*FEATURE_BITS-1:0]    ag_address,
    input  logic                         ag_done,
    output logic                         rd_en,
    output logic [2*FEATURE_BITS-1:0]    rd_addr,
    input  logic [ROWS*DATA_WIDTH-1:0]   rd_data,
    output logic [ROWS*DATA_WIDTH-1:0]   sa_data,
    output logic [ROWS-1:0]              sa_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int CW = $clog2(ROWS + 2);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

    state_e         state_q;
    logic [CW-1:0]  drain_cnt_q;
    logic           ag_start_q;
    logic           busy_q;
    logic           done_q;
    logic           rv_q;

    // The STREAM cycle that first sees ag_done counts as the first of the ROWS+1 drain cycles,
    // so the last skewed row leaves the pipe in the final DRAIN cycle and done follows directly.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            ag_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && !ag_done) begin
                    state_q    <= STREAM;
                    ag_start_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                STREAM: if (ag_done) begin
                    state_q     <= DRAIN;
                    ag_start_q  <= 1'b0;
                    drain_cnt_q <= CW'(1);
                end
                DRAIN: if (drain_cnt_q == CW'(ROWS)) begin
                    state_q     <= DONE;
                    done_q      <= 1'b1;
                    drain_cnt_q <= '0;
                end else begin
                    drain_cnt_q <= drain_cnt_q + CW'(1);
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ag_start = ag_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = ag_start_q && !ag_done;
    assign rd_addr  = ag_address;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) rv_q <= 1'b0;
        else          rv_q <= rd_en;
    end

    // Row r sits behind r+1 stages; data is zeroed at the output whenever its valid is low.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int ST = r + 1;
        logic [DATA_WIDTH-1:0] dat_q [0:r];
        logic [r:0]            vld_q;

        always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= '0;
                for (int s = 0; s <= r; s++) dat_q[s] <= '0;
            end else begin
                vld_q    <= (vld_q << 1) | ST'(rv_q);
                dat_q[0] <= rd_data[r*DATA_WIDTH +: DATA_WIDTH];
                for (int s = 1; s <= r; s++) dat_q[s] <= dat_q[s-1];
            end
        end

        assign sa_valid[r]                          = vld_q[r];
        assign sa_data[r*DATA_WIDTH +: DATA_WIDTH]  = vld_q[r] ? dat_q[r] : '0;
    end

endmodule

// File: tb/tb_temp_buff_feeder.sv
// Scoreboard bench: a behavioural address-generator/buffer model predicts every read, skewed row
// element and done pulse; a negedge monitor pops and compares whatever the DUT presents.
module tb_temp_buff_feeder;
    localparam int FB = 4, DW = 8, ROWS = 4, AW = 2*FB;

    logic sys_clk = 1'b0, reset_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic               start, ag_start, ag_done, rd_en, busy, done;
    logic [AW-1:0]      ag_address, rd_addr;
    logic [ROWS*DW-1:0] rd_data, sa_data;
    logic [ROWS-1:0]    sa_valid;

    logic               start1, ag_start1, ag_done1, rd_en1, busy1, done1;
    logic [AW-1:0]      ag_address1, rd_addr1;
    logic [DW-1:0]      rd_data1, sa_data1;
    logic [0:0]         sa_valid1;

    temp_buff_feeder #(.FEATURE_BITS(FB), .DATA_WIDTH(DW), .ROWS(ROWS)) u_dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .ag_start(ag_start),
        .ag_address(ag_address), .ag_done(ag_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .sa_data(sa_data), .sa_valid(sa_valid), .busy(busy), .done(done));

    temp_buff_feeder #(.FEATURE_BITS(FB), .DATA_WIDTH(DW), .ROWS(1)) u_dut1 (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start1), .ag_start(ag_start1),
        .ag_address(ag_address1), .ag_done(ag_done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .sa_data(sa_data1), .sa_valid(sa_valid1), .busy(busy1), .done(done1));

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address generator model: row-major walk of nrow x ncol with a row stride (zero-pad skips).
    int ncol = 8, stride = 9, nreads = 64;
    int idx_q;
    logic agd_q, force_done = 1'b0;
    always @(posedge sys_clk or negedge reset_n)
        if (!reset_n) begin idx_q <= 0; agd_q <= 1'b0; end
        else if (ag_start && !ag_done) begin
            if (idx_q == nreads - 1) agd_q <= 1'b1;
            else idx_q <= idx_q + 1;
        end else if (!ag_start) idx_q <= 0;
    assign ag_done = agd_q | force_done;
    always @* ag_address = AW'((idx_q / ncol) * stride + idx_q % ncol);

    logic [ROWS*DW-1:0] mem [256];
    always @(posedge sys_clk) rd_data <= rd_en ? mem[rd_addr] : ROWS*DW'($urandom);

    // Single-address stub for the ROWS=1 instance.
    logic agd1_q;
    always @(posedge sys_clk or negedge reset_n)
        if (!reset_n) agd1_q <= 1'b0;
        else if (ag_start1) agd1_q <= 1'b1;
    assign ag_done1    = agd1_q;
    assign ag_address1 = '0;
    always @(posedge sys_clk) rd_data1 <= rd_en1 ? 8'hA5 : DW'($urandom);

    typedef struct { int cyc; int val; } exp_t;
    exp_t addr_q [$];
    exp_t row_q  [ROWS][$];
    int   done_q [$];
    int   busy_lo = 0, busy_hi = 0, run_lo = 0, run_n = 0;
    bit   mon_en = 1'b0;

    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (rd_en) begin
                if (addr_q.size() == 0) chk("rd_en_unexpected", 1, 0);
                else begin
                    e = addr_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", rd_addr, e.val);
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (sa_valid[r]) begin
                    if (row_q[r].size() == 0) chk("sa_valid_unexpected", r + 1, 0);
                    else begin
                        e = row_q[r].pop_front();
                        chk("sa_row_cycle", cyc, e.cyc);
                        chk("sa_row_data", sa_data[r*DW +: DW], e.val);
                    end
                end else chk("sa_row_zero", sa_data[r*DW +: DW], 0);
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            chk("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
            if (cyc >= run_lo && cyc < run_lo + run_n) chk("ag_start_hi", ag_start, 1);
            else if (cyc != run_lo + run_n)             chk("ag_start_lo", ag_start, 0);
        end
    end

    // Called at a negedge: start is sampled at the next posedge, so cycle 0 is cyc+1.
    task automatic issue_start();
        int t0 = cyc + 1;
        logic [AW-1:0] a;
        for (int k = 0; k < nreads; k++) begin
            a = AW'((k / ncol) * stride + k % ncol);
            addr_q.push_back('{t0 + k, int'(a)});
            for (int r = 0; r < ROWS; r++)
                row_q[r].push_back('{t0 + k + 2 + r, int'(mem[a][r*DW +: DW])});
        end
        done_q.push_back(t0 + nreads + ROWS + 1);
        busy_lo = t0; busy_hi = t0 + nreads + ROWS + 2;
        run_lo  = t0; run_n   = nreads;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic run_wait(input bit poke);
        repeat (nreads + ROWS + 8) begin
            @(negedge sys_clk);
            start = poke && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        chk("addr_q_empty", addr_q.size(), 0);
        for (int r = 0; r < ROWS; r++) chk("row_q_empty", row_q[r].size(), 0);
        chk("done_q_empty", done_q.size(), 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_ag_start", ag_start, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_sa_data", sa_data, 0);
        chk("rst_sa_valid", sa_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst1_busy", busy1, 0);
        addr_q.delete(); done_q.delete();
        for (int r = 0; r < ROWS; r++) row_q[r].delete();
        busy_lo = 0; busy_hi = 0; run_lo = 0; run_n = 0;
        force_done = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic rand_mem();
        for (int a = 0; a < 256; a++) mem[a] = ROWS*DW'($urandom);
    endtask

    initial begin
        int t0;
        start = 1'b0; start1 = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = {ROWS{8'(a)}};
        @(negedge sys_clk);
        do_reset();

        // ROWS=1 instance, single address then ag_done.
        start1 = 1'b1;
        t0 = cyc + 1;
        @(negedge sys_clk);
        start1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("r1_cycle", cyc, t0 + c);
            chk("r1_rd_en", rd_en1, c == 0);
            if (c == 0) chk("r1_rd_addr", rd_addr1, 0);
            chk("r1_sa_valid", sa_valid1, c == 2);
            chk("r1_sa_data", sa_data1, (c == 2) ? 8'hA5 : 8'h00);
            chk("r1_done", done1, c == 3);
            chk("r1_busy", busy1, c <= 3);
            @(negedge sys_clk);
        end

        // Full 8x8 walk with stride 9 over word {4{a}}.
        ncol = 8; stride = 9; nreads = 64;
        issue_start();
        run_wait(1'b0);

        // Same walk with stray start pulses during and after the run.
        do_reset();
        rand_mem();
        issue_start();
        run_wait(1'b1);

        // Reset at cycle 30, then a fresh run from address 0.
        do_reset();
        issue_start();
        repeat (30) @(negedge sys_clk);
        do_reset();
        issue_start();
        run_wait(1'b0);

        // ag_done already high: start must be ignored.
        do_reset();
        force_done = 1'b1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (8) begin
            @(negedge sys_clk);
            chk("agd_busy", busy, 0);
            chk("agd_rd_en", rd_en, 0);
            chk("agd_ag_start", ag_start, 0);
            chk("agd_done", done, 0);
        end

        for (int i = 0; i < 6; i++) begin
            do_reset();
            rand_mem();
            ncol   = $urandom_range(1, 8);
            stride = ncol + $urandom_range(0, 2);
            nreads = ncol * $urandom_range(1, 6);
            issue_start();
            run_wait(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
